// File: rtl/byte_unstriping_pkg.sv
// Shared lane-striping definitions used by the transmit and receive byte-striping stages.
// Also holds the 8b/10b-style control symbols that later receive stages and the bench decode.
package byte_unstriping_pkg;

   localparam int LANES = 4;
   localparam int DW    = 8;

   localparam logic [7:0] COM  = 8'hBC;
   localparam logic [7:0] SKP  = 8'h1C;
   localparam logic [7:0] STP  = 8'hFB;
   localparam logic [7:0] SDP  = 8'h5C;
   localparam logic [7:0] END  = 8'hFD;
   localparam logic [7:0] EDB  = 8'hFE;
   localparam logic [7:0] FTS  = 8'h3C;
   localparam logic [7:0] IDLE = 8'h7C;

   typedef logic [1:0] lane_idx_t;

   // Round-robin successor; lane 3 is the last byte of a group.
   function automatic lane_idx_t next_lane(input lane_idx_t idx);
      return idx + 2'd1;
   endfunction

   function automatic logic is_last_lane(input lane_idx_t idx);
      return idx == lane_idx_t'(LANES - 1);
   endfunction

endpackage

// File: rtl/byte_unstriping_fifo_grupo.sv
// Synchronous FIFO of whole striped groups; push is ignored when full, pop when empty.
// Zero read latency: o_rdata always shows the head entry. Synchronous active-low reset.
module fifo_grupo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/byte_unstriping.sv
// Re-serializes 4-lane striped groups into one byte stream, lane0 first; 1 clk from push to lane0.
// Back-pressure via rx_ready when the group FIFO is full; refused offers set a sticky overflow flag.
module byte_unstriping #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic [DW-1:0] rx_lane0,
   input  logic [DW-1:0] rx_lane1,
   input  logic [DW-1:0] rx_lane2,
   input  logic [DW-1:0] rx_lane3,
   input  logic          rx_group_valid,
   output logic          rx_ready,
   output logic [DW-1:0] rx_Data,
   output logic          rx_Valid,
   output logic          overflow_err
);

   import byte_unstriping_pkg::*;

   localparam int GW = LANES * DW;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [GW-1:0]              w_wdata;
   logic [GW-1:0]              w_rdata;
   logic [LANES-1:0][DW-1:0]   w_rd_lanes;
   logic                       w_full;
   logic                       w_empty;
   logic [CW-1:0]              w_count;
   logic                       w_push;
   logic                       w_pop;
   logic [DW-1:0]              w_byte;

   lane_idx_t                  r_lane_idx;
   logic [DW-1:0]              r_data;
   logic                       r_valid;
   logic                       r_ovf;

   // Gated by rst so nothing is accepted or refused while reset is held.
   assign rx_ready = rst && enb && !w_full;
   assign w_push   = rx_group_valid && rx_ready;
   assign w_pop    = enb && (w_count != '0) && is_last_lane(r_lane_idx);

   assign w_wdata    = {rx_lane3, rx_lane2, rx_lane1, rx_lane0};
   assign w_rd_lanes = w_rdata;
   assign w_byte     = w_rd_lanes[r_lane_idx];

   fifo_grupo #(
      .WIDTH (GW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lane_idx <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ovf      <= 1'b0;
      end else if (enb) begin
         if (!w_empty) begin
            r_data     <= w_byte;
            r_valid    <= 1'b1;
            r_lane_idx <= next_lane(r_lane_idx);
         end else begin
            r_data     <= '0;
            r_valid    <= 1'b0;
         end
         if (rx_group_valid && !rx_ready) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign rx_Data      = r_data;
   assign rx_Valid     = r_valid;
   assign overflow_err = r_ovf;

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: reset, latency, back-pressure, full boundary, enable hold, mid-group reset.
module tb_byte_unstriping;

   import byte_unstriping_pkg::*;

   logic       clk;
   logic       rst;
   logic       enb;
   logic [7:0] rx_lane0;
   logic [7:0] rx_lane1;
   logic [7:0] rx_lane2;
   logic [7:0] rx_lane3;
   logic       rx_group_valid;
   logic       rx_ready;
   logic [7:0] rx_Data;
   logic       rx_Valid;
   logic       overflow_err;

   int         vecs = 0;
   int         errs = 0;
   logic       exp_rdy [8];
   logic [7:0] exp_q [$];

   byte_unstriping #(.DEPTH(4), .DW(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .enb            (enb),
      .rx_lane0       (rx_lane0),
      .rx_lane1       (rx_lane1),
      .rx_lane2       (rx_lane2),
      .rx_lane3       (rx_lane3),
      .rx_group_valid (rx_group_valid),
      .rx_ready       (rx_ready),
      .rx_Data        (rx_Data),
      .rx_Valid       (rx_Valid),
      .overflow_err   (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic exp_v, input logic [7:0] exp_d);
      chk({tag, "_valid"}, {31'd0, rx_Valid}, {31'd0, exp_v});
      chk({tag, "_data"},  {24'd0, rx_Data},  {24'd0, exp_d});
   endtask

   task automatic send(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
      rx_lane0       = b0;
      rx_lane1       = b1;
      rx_lane2       = b2;
      rx_lane3       = b3;
      rx_group_valid = 1'b1;
   endtask

   initial begin
      logic [7:0] sg [4];
      logic [7:0] b;

      // Reset held two clocks while a group is offered
      rst = 1'b0;
      enb = 1'b1;
      send(8'h01, 8'h02, 8'h03, 8'h04);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ready", {31'd0, rx_ready}, 32'd0);
         chk("rst_ovf", {31'd0, overflow_err}, 32'd0);
         chk_out("rst_out", 1'b0, 8'h00);
      end
      rst = 1'b1;
      rx_group_valid = 1'b0;
      #1;
      chk("rel_ready", {31'd0, rx_ready}, 32'd1);

      // Single group: lane0 one edge after the push, then one byte per clock
      sg = '{8'h11, 8'h22, 8'h33, 8'h44};
      send(sg[0], sg[1], sg[2], sg[3]);
      tick();
      rx_group_valid = 1'b0;
      chk_out("single_push_edge", 1'b0, 8'h00);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk_out("single_byte", 1'b1, sg[j]);
      end
      tick();
      chk_out("single_idle", 1'b0, 8'h00);

      // Back-to-back offers of 8 groups; a pop at the 5th edge frees a slot for group 6
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         if (exp_rdy[k]) begin
            for (int j = 0; j < 4; j++) begin
               exp_q.push_back(8'((k + 1) * 16 + j));
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         send(8'((k + 1) * 16), 8'((k + 1) * 16 + 1), 8'((k + 1) * 16 + 2), 8'((k + 1) * 16 + 3));
         chk("b2b_ready", {31'd0, rx_ready}, {31'd0, exp_rdy[k]});
         tick();
         chk("b2b_ovf", {31'd0, overflow_err}, (k >= 4) ? 32'd1 : 32'd0);
         if (k == 0) chk_out("b2b_first", 1'b0, 8'h00);
         else        chk_out("b2b_stream", 1'b1, exp_q[k - 1]);
      end
      rx_group_valid = 1'b0;
      for (int n = 7; n < 20; n++) begin
         tick();
         chk_out("b2b_drain", 1'b1, exp_q[n]);
      end
      tick();
      chk_out("b2b_idle", 1'b0, 8'h00);
      chk("b2b_ovf_sticky", {31'd0, overflow_err}, 32'd1);

      rst = 1'b0;
      tick();
      chk("rst2_ovf", {31'd0, overflow_err}, 32'd0);
      rst = 1'b1;

      // Fill to full, then offer right after the head's lane3 pops
      for (int g = 0; g < 4; g++) begin
         send(8'(4 * g + 1), 8'(4 * g + 2), 8'(4 * g + 3), 8'(4 * g + 4));
         tick();
         if (g == 0) chk_out("bnd_fill_first", 1'b0, 8'h00);
         else        chk_out("bnd_fill", 1'b1, 8'(g));
      end
      rx_group_valid = 1'b0;
      chk("bnd_full_ready", {31'd0, rx_ready}, 32'd0);
      tick();
      chk_out("bnd_lane3", 1'b1, 8'h04);
      send(8'h11, 8'h12, 8'h13, 8'h14);
      chk("bnd_ready", {31'd0, rx_ready}, 32'd1);
      tick();
      rx_group_valid = 1'b0;
      chk("bnd_full_again", {31'd0, rx_ready}, 32'd0);
      chk("bnd_ovf", {31'd0, overflow_err}, 32'd0);
      chk_out("bnd_next", 1'b1, 8'h05);
      for (int n = 5; n < 20; n++) begin
         tick();
         chk_out("bnd_drain", 1'b1, 8'(n + 1));
      end
      tick();
      chk_out("bnd_idle", 1'b0, 8'h00);

      // Enable low mid-group holds outputs and refuses without flagging overflow
      send(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      tick();
      rx_group_valid = 1'b0;
      tick();
      chk_out("enb_b0", 1'b1, 8'hAA);
      tick();
      chk_out("enb_b1", 1'b1, 8'hBB);
      enb = 1'b0;
      send(8'h01, 8'h02, 8'h03, 8'h04);
      #1;
      chk("enb_ready", {31'd0, rx_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("enb_hold", 1'b1, 8'hBB);
         chk("enb_hold_ready", {31'd0, rx_ready}, 32'd0);
         chk("enb_ovf", {31'd0, overflow_err}, 32'd0);
      end
      enb = 1'b1;
      rx_group_valid = 1'b0;
      tick();
      chk_out("enb_b2", 1'b1, 8'hCC);
      tick();
      chk_out("enb_b3", 1'b1, 8'hDD);
      tick();
      chk_out("enb_idle", 1'b0, 8'h00);

      // Reset with two groups buffered and two bytes already emitted
      send(8'h01, 8'h02, 8'h03, 8'h04);
      tick();
      send(8'h05, 8'h06, 8'h07, 8'h08);
      tick();
      chk_out("mid_b0", 1'b1, 8'h01);
      rx_group_valid = 1'b0;
      tick();
      chk_out("mid_b1", 1'b1, 8'h02);
      rst = 1'b0;
      tick();
      chk_out("mid_rst", 1'b0, 8'h00);
      chk("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
      rst = 1'b1;
      send(COM, SKP, SKP, SKP);
      tick();
      rx_group_valid = 1'b0;
      chk_out("mid_push_edge", 1'b0, 8'h00);
      for (int j = 0; j < 4; j++) begin
         tick();
         b = (j == 0) ? COM : SKP;
         chk_out("mid_sym", 1'b1, b);
      end
      tick();
      chk_out("mid_idle", 1'b0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
